// File: rtl/vref_cal_tx.sv
// Initiator side of the MBTRAIN Rx-Vref calibration sideband handshake.
// Optional timeout path is built only when VREF_CAL_TX_TIMEOUT_EN is defined.
module vref_cal_tx #(
    parameter int unsigned TIMEOUT_CYCLES = 8000000,
    parameter int unsigned CNT_W          = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [3:0] i_decoded_sideband_message,
    input  logic       i_sideband_valid,
    input  logic       i_busy_negedge_detected,
    input  logic       i_valid_rx,
    input  logic       i_mainband_or_valtrain_test,
    input  logic       i_pt_done,
    output logic [3:0] o_sideband_message,
    output logic       o_valid_tx,
    output logic       o_pt_en,
    output logic       o_valpattern_en,
    output logic       o_test_ack,
    output logic       o_timeout
);

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        SEND_START_REQ  = 3'd1,
        WAIT_START_RESP = 3'd2,
        RUN_TEST        = 3'd3,
        SEND_END_REQ    = 3'd4,
        WAIT_END_RESP   = 3'd5,
        TEST_FINISHED   = 3'd6,
        TIMEOUT_ERR     = 3'd7
    } state_t;

    localparam logic [3:0] MSG_NONE       = 4'b0000;
    localparam logic [3:0] MSG_START_REQ  = 4'b0001;
    localparam logic [3:0] MSG_START_RESP = 4'b0010;
    localparam logic [3:0] MSG_END_REQ    = 4'b0011;
    localparam logic [3:0] MSG_END_RESP   = 4'b0100;

    state_t     state_q;
    logic [3:0] msg_q;
    logic       valid_q;
    logic       valid_prev_q;
    logic       pend_q;
    logic       pt_en_q;
    logic       valpat_q;
    logic       ack_q;

    logic start_resp_ok;
    logic end_resp_ok;
    logic valid_fell;

    assign start_resp_ok = i_sideband_valid && (i_decoded_sideband_message == MSG_START_RESP);
    assign end_resp_ok   = i_sideband_valid && (i_decoded_sideband_message == MSG_END_RESP);
    assign valid_fell    = valid_prev_q && !valid_q;

`ifdef VREF_CAL_TX_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             expired;

    assign expired   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_timeout = timeout_q;

    logic unused_ok;
    assign unused_ok = i_valid_rx;
`else
    assign o_timeout = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{i_valid_rx, (TIMEOUT_CYCLES == 0), (CNT_W == 0)};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            msg_q        <= '0;
            valid_q      <= 1'b0;
            valid_prev_q <= 1'b0;
            pend_q       <= 1'b0;
            pt_en_q      <= 1'b0;
            valpat_q     <= 1'b0;
            ack_q        <= 1'b0;
`ifdef VREF_CAL_TX_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else if (!i_en) begin
            state_q      <= IDLE;
            msg_q        <= '0;
            valid_q      <= 1'b0;
            valid_prev_q <= 1'b0;
            pend_q       <= 1'b0;
            pt_en_q      <= 1'b0;
            valpat_q     <= 1'b0;
            ack_q        <= 1'b0;
`ifdef VREF_CAL_TX_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            valid_prev_q <= valid_q;

            // Initiator owns the shared mux: assert regardless of i_valid_rx.
            // Busy negedges seen while not driving belong to the responder.
            if (pend_q && !valid_q) begin
                valid_q <= 1'b1;
            end else if (valid_q && i_busy_negedge_detected) begin
                valid_q <= 1'b0;
                pend_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    state_q <= SEND_START_REQ;
                    msg_q   <= MSG_START_REQ;
                    pend_q  <= 1'b1;
                end
                SEND_START_REQ: begin
                    if (valid_fell) begin
                        state_q <= WAIT_START_RESP;
`ifdef VREF_CAL_TX_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                WAIT_START_RESP: begin
                    if (start_resp_ok) begin
                        state_q  <= RUN_TEST;
                        pt_en_q  <= ~i_mainband_or_valtrain_test;
                        valpat_q <= i_mainband_or_valtrain_test;
`ifdef VREF_CAL_TX_TIMEOUT_EN
                    end else if (expired) begin
                        state_q   <= TIMEOUT_ERR;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                RUN_TEST: begin
                    if (i_pt_done) begin
                        state_q  <= SEND_END_REQ;
                        pt_en_q  <= 1'b0;
                        valpat_q <= 1'b0;
                        msg_q    <= MSG_END_REQ;
                        pend_q   <= 1'b1;
                    end
                end
                SEND_END_REQ: begin
                    if (valid_fell) begin
                        state_q <= WAIT_END_RESP;
`ifdef VREF_CAL_TX_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                WAIT_END_RESP: begin
                    if (end_resp_ok) begin
                        state_q <= TEST_FINISHED;
                        ack_q   <= 1'b1;
                        msg_q   <= MSG_NONE;
`ifdef VREF_CAL_TX_TIMEOUT_EN
                    end else if (expired) begin
                        state_q   <= TIMEOUT_ERR;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                TEST_FINISHED: begin
                    state_q <= TEST_FINISHED;
                end
`ifdef VREF_CAL_TX_TIMEOUT_EN
                TIMEOUT_ERR: begin
                    state_q  <= TIMEOUT_ERR;
                    valid_q  <= 1'b0;
                    pend_q   <= 1'b0;
                    pt_en_q  <= 1'b0;
                    valpat_q <= 1'b0;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_sideband_message = msg_q;
    assign o_valid_tx         = valid_q;
    assign o_pt_en            = pt_en_q;
    assign o_valpattern_en    = valpat_q;
    assign o_test_ack         = ack_q;

endmodule

// File: tb/tb_vref_cal_tx.sv
// Directed bench for vref_cal_tx; observed vector is
// {message, valid_tx, pt_en, valpattern_en, test_ack, timeout, state}.
module tb_vref_cal_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] sb_msg;
    logic       sb_valid;
    logic       busy;
    logic       valid_rx;
    logic       mb;
    logic       pt_done;
    logic [3:0] o_sideband_message;
    logic       o_valid_tx;
    logic       o_pt_en;
    logic       o_valpattern_en;
    logic       o_test_ack;
    logic       o_timeout;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    vref_cal_tx #(
        .TIMEOUT_CYCLES(16),
        .CNT_W(5)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .i_en                       (en),
        .i_decoded_sideband_message (sb_msg),
        .i_sideband_valid           (sb_valid),
        .i_busy_negedge_detected    (busy),
        .i_valid_rx                 (valid_rx),
        .i_mainband_or_valtrain_test(mb),
        .i_pt_done                  (pt_done),
        .o_sideband_message         (o_sideband_message),
        .o_valid_tx                 (o_valid_tx),
        .o_pt_en                    (o_pt_en),
        .o_valpattern_en            (o_valpattern_en),
        .o_test_ack                 (o_test_ack),
        .o_timeout                  (o_timeout)
    );

    logic [2:0]  st;
    logic [11:0] obsv;
    assign st   = dut.state_q;
    assign obsv = {o_sideband_message, o_valid_tx, o_pt_en, o_valpattern_en, o_test_ack, o_timeout, st};

    // Rising-edge monitor of o_valid_tx, logging the message carried by each pulse
    int         pulses = 0;
    logic [3:0] log_q[$];
    logic       prev_v = 1'b0;
    always @(negedge clk) begin
        if (o_valid_tx && !prev_v) begin
            pulses++;
            log_q.push_back(o_sideband_message);
        end
        prev_v = o_valid_tx;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_msg(input logic [3:0] code);
        sb_msg   = code;
        sb_valid = 1'b1;
        step();
        sb_valid = 1'b0;
        sb_msg   = 4'h0;
    endtask

    // Waits for o_valid_tx, answers with a busy negedge 3 cycles later, then
    // steps once more so the FSM has moved into its WAIT state.
    task automatic serialize(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !o_valid_tx; i++) step();
        if (o_valid_tx) begin
            ok = 1'b1;
            step();
            step();
            busy = 1'b1;
            step();
            busy = 1'b0;
            step();
        end
    endtask

    task automatic abort_idle();
        en = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst_n = 1'b0; en = 1'b0; sb_msg = '0; sb_valid = 1'b0; busy = 1'b0;
        valid_rx = 1'b0; mb = 1'b0; pt_done = 1'b0;
        step(); step();
        e = '0;
        tests++; if (obsv !== e) begin failed++; $display("FAIL reset_hold: got %h expected %h", obsv, e); end
        rst_n = 1'b1;
        step();
        tests++; if (obsv !== e) begin failed++; $display("FAIL reset_release: got %h expected %h", obsv, e); end
    endtask

    task automatic test_mainband();
        logic [11:0] e;
        bit ok;
        int bad = 0;
        pulses = 0; log_q.delete();
        mb = 1'b0; en = 1'b1;
        step();
        e = {4'h1, 5'b00000, 3'd1};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mb_start_entry: got %h expected %h", obsv, e); end
        step();
        e = {4'h1, 5'b10000, 3'd1};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mb_start_valid: got %h expected %h", obsv, e); end
        serialize(ok);
        tests++; if (!ok) begin failed++; $display("FAIL mb_start_serialize: got no valid expected valid"); end
        e = {4'h1, 5'b00000, 3'd2};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mb_wait_start: got %h expected %h", obsv, e); end
        send_msg(4'h2);
        e = {4'h1, 5'b01000, 3'd3};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mb_run_entry: got %h expected %h", obsv, e); end
        for (int i = 0; i < 20; i++) begin
            step();
            if (obsv !== e) bad++;
        end
        tests++; if (bad != 0) begin failed++; $display("FAIL mb_run_hold: got %0d bad cycles expected 0", bad); end
        pt_done = 1'b1;
        step();
        pt_done = 1'b0;
        e = {4'h3, 5'b00000, 3'd4};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mb_end_entry: got %h expected %h", obsv, e); end
        step();
        e = {4'h3, 5'b10000, 3'd4};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mb_end_valid: got %h expected %h", obsv, e); end
        serialize(ok);
        e = {4'h3, 5'b00000, 3'd5};
        tests++; if (!ok || obsv !== e) begin failed++; $display("FAIL mb_wait_end: got %h expected %h", obsv, e); end
        send_msg(4'h4);
        e = {4'h0, 5'b00010, 3'd6};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mb_finished: got %h expected %h", obsv, e); end
        step(); step(); step();
        tests++; if (obsv !== e) begin failed++; $display("FAIL mb_finished_hold: got %h expected %h", obsv, e); end
        tests++;
        if (pulses != 2 || log_q.size() != 2 || log_q[0] !== 4'h1 || log_q[1] !== 4'h3) begin
            failed++;
            $display("FAIL mb_pulses: got %0d pulses expected 2 (messages 1,3)", pulses);
        end
        abort_idle();
        e = '0;
        tests++; if (obsv !== e) begin failed++; $display("FAIL mb_release: got %h expected %h", obsv, e); end
    endtask

    task automatic test_valtrain();
        logic [11:0] e;
        bit ok;
        mb = 1'b1; en = 1'b1;
        step();
        serialize(ok);
        send_msg(4'h2);
        e = {4'h1, 5'b00100, 3'd3};
        tests++; if (!ok || obsv !== e) begin failed++; $display("FAIL vt_run_entry: got %h expected %h", obsv, e); end
        step(); step(); step(); step(); step();
        tests++; if (obsv !== e) begin failed++; $display("FAIL vt_run_hold: got %h expected %h", obsv, e); end
        pt_done = 1'b1;
        step();
        pt_done = 1'b0;
        e = {4'h3, 5'b00000, 3'd4};
        tests++; if (obsv !== e) begin failed++; $display("FAIL vt_done: got %h expected %h", obsv, e); end
        abort_idle();
        mb = 1'b0;
    endtask

    task automatic test_wrong_codes();
        logic [11:0] e;
        bit ok;
        en = 1'b1;
        step();
        serialize(ok);
        e = {4'h1, 5'b00000, 3'd2};
        tests++; if (!ok || obsv !== e) begin failed++; $display("FAIL wc_wait: got %h expected %h", obsv, e); end
        send_msg(4'h4);
        tests++; if (obsv !== e) begin failed++; $display("FAIL wc_code4: got %h expected %h", obsv, e); end
        send_msg(4'h3);
        tests++; if (obsv !== e) begin failed++; $display("FAIL wc_code3: got %h expected %h", obsv, e); end
        sb_msg = 4'h2;
        step();
        sb_msg = 4'h0;
        tests++; if (obsv !== e) begin failed++; $display("FAIL wc_no_valid: got %h expected %h", obsv, e); end
        pt_done = 1'b1;
        step();
        pt_done = 1'b0;
        tests++; if (obsv !== e) begin failed++; $display("FAIL wc_stray_pt_done: got %h expected %h", obsv, e); end
        send_msg(4'h2);
        e = {4'h1, 5'b01000, 3'd3};
        tests++; if (obsv !== e) begin failed++; $display("FAIL wc_accept: got %h expected %h", obsv, e); end
        abort_idle();
    endtask

    task automatic test_mux_priority();
        logic [11:0] e;
        valid_rx = 1'b1; en = 1'b1;
        step();
        e = {4'h1, 5'b00000, 3'd1};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mp_pending: got %h expected %h", obsv, e); end
        busy = 1'b1;
        step();
        busy = 1'b0;
        e = {4'h1, 5'b10000, 3'd1};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mp_valid_asserts: got %h expected %h", obsv, e); end
        step(); step();
        tests++; if (obsv !== e) begin failed++; $display("FAIL mp_valid_holds: got %h expected %h", obsv, e); end
        busy = 1'b1;
        step();
        busy = 1'b0;
        e = {4'h1, 5'b00000, 3'd1};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mp_valid_clears: got %h expected %h", obsv, e); end
        step();
        e = {4'h1, 5'b00000, 3'd2};
        tests++; if (obsv !== e) begin failed++; $display("FAIL mp_to_wait: got %h expected %h", obsv, e); end
        step(); step(); step();
        tests++; if (obsv !== e) begin failed++; $display("FAIL mp_single_pulse: got %h expected %h", obsv, e); end
        valid_rx = 1'b0;
        abort_idle();
    endtask

`ifdef VREF_CAL_TX_TIMEOUT_EN
    task automatic test_timeout();
        logic [11:0] e;
        bit ok;
        en = 1'b1;
        step();
        serialize(ok);
        for (int i = 0; i < 15; i++) step();
        e = {4'h1, 5'b00000, 3'd2};
        tests++; if (!ok || obsv !== e) begin failed++; $display("FAIL to_before_expiry: got %h expected %h", obsv, e); end
        step();
        e = {4'h1, 5'b00001, 3'd7};
        tests++; if (obsv !== e) begin failed++; $display("FAIL to_expired: got %h expected %h", obsv, e); end
        step(); step();
        tests++; if (obsv !== e) begin failed++; $display("FAIL to_sticky: got %h expected %h", obsv, e); end
        abort_idle();
        e = '0;
        tests++; if (obsv !== e) begin failed++; $display("FAIL to_release: got %h expected %h", obsv, e); end
        en = 1'b1;
        step();
        serialize(ok);
        for (int i = 0; i < 15; i++) step();
        send_msg(4'h2);
        e = {4'h1, 5'b01000, 3'd3};
        tests++; if (!ok || obsv !== e) begin failed++; $display("FAIL to_resp_wins: got %h expected %h", obsv, e); end
        abort_idle();
    endtask
`else
    task automatic test_timeout();
        logic [11:0] e;
        bit ok;
        en = 1'b1;
        step();
        serialize(ok);
        for (int i = 0; i < 40; i++) step();
        e = {4'h1, 5'b00000, 3'd2};
        tests++; if (!ok || obsv !== e) begin failed++; $display("FAIL to_disabled_wait: got %h expected %h", obsv, e); end
        abort_idle();
    endtask
`endif

    task automatic test_abort();
        logic [11:0] e;
        bit ok;
        en = 1'b1;
        step();
        serialize(ok);
        send_msg(4'h2);
        pt_done = 1'b1;
        step();
        pt_done = 1'b0;
        step();
        e = {4'h3, 5'b10000, 3'd4};
        tests++; if (!ok || obsv !== e) begin failed++; $display("FAIL ab_mid_message: got %h expected %h", obsv, e); end
        abort_idle();
        e = '0;
        tests++; if (obsv !== e) begin failed++; $display("FAIL ab_cleared: got %h expected %h", obsv, e); end
        en = 1'b1;
        step();
        e = {4'h1, 5'b00000, 3'd1};
        tests++; if (obsv !== e) begin failed++; $display("FAIL ab_restart: got %h expected %h", obsv, e); end
        step();
        e = {4'h1, 5'b10000, 3'd1};
        tests++; if (obsv !== e) begin failed++; $display("FAIL ab_restart_valid: got %h expected %h", obsv, e); end
        serialize(ok);
        send_msg(4'h2);
        en = 1'b0;
        pt_done = 1'b1;
        step();
        pt_done = 1'b0;
        e = '0;
        tests++; if (!ok || obsv !== e) begin failed++; $display("FAIL ab_wins_over_pt_done: got %h expected %h", obsv, e); end
    endtask

    initial begin
        test_reset();
        test_mainband();
        test_valtrain();
        test_wrong_codes();
        test_mux_priority();
        test_timeout();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
